// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - checks observed 8-gate outputs against golden truth table per {a,b}
module gate_response_checker #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       a,
   input  logic       b,
   input  logic [7:0] gate_obs,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       timed_out,
   output logic [7:0] err_map,
   output logic [7:0] err_cnt,
   output logic [7:0] vec_cnt,
   output logic [3:0] cov
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Last idle-counter value before the session is declared timed out.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   state_t     state_nx;
   logic [7:0] to_cnt;
   logic [7:0] to_cnt_nx;
   logic [7:0] err_map_nx;
   logic [7:0] err_cnt_nx;
   logic [7:0] vec_cnt_nx;
   logic [3:0] cov_nx;
   logic       timed_out_nx;
   logic       pass_nx;

   logic [7:0] golden;
   logic [7:0] mism;
   logic [7:0] map_upd;
   logic [3:0] cov_upd;

   // Expected gate outputs for the applied stimulus (bit order matches gate_obs).
   always_comb begin
      golden = 8'h00;
      case ({a, b})
         2'b00:   golden = 8'hEC;
         2'b01:   golden = 8'h36;
         2'b10:   golden = 8'h3A;
         default: golden = 8'h83;
      endcase
   end

   assign mism    = gate_obs ^ golden;
   assign map_upd = err_map | mism;
   assign cov_upd = cov | (4'b0001 << {a, b});

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   // Next-state and result update; start always opens a fresh session and wins over a vector.
   always_comb begin
      state_nx     = state;
      to_cnt_nx    = to_cnt;
      err_map_nx   = err_map;
      err_cnt_nx   = err_cnt;
      vec_cnt_nx   = vec_cnt;
      cov_nx       = cov;
      timed_out_nx = timed_out;
      pass_nx      = pass;

      case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            if (!start) begin
               if (in_valid) begin
                  err_map_nx = map_upd;
                  if (mism != 8'h00 && err_cnt != 8'hFF) err_cnt_nx = err_cnt + 8'd1;
                  if (vec_cnt != 8'hFF) vec_cnt_nx = vec_cnt + 8'd1;
                  cov_nx    = cov_upd;
                  to_cnt_nx = 8'h00;
                  // Coverage completion takes priority; a timeout cannot fire on an accepting edge.
                  if (cov_upd == 4'hF) begin
                     state_nx = DONE;
                     pass_nx  = (map_upd == 8'h00);
                  end
               end else if (to_cnt == TO_LAST) begin
                  state_nx     = DONE;
                  timed_out_nx = 1'b1;
                  pass_nx      = 1'b0;
               end else begin
                  to_cnt_nx = to_cnt + 8'd1;
               end
            end
         end
         DONE: begin
            if (start) state_nx = RUN;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      if (start) begin
         state_nx     = RUN;
         to_cnt_nx    = 8'h00;
         err_map_nx   = 8'h00;
         err_cnt_nx   = 8'h00;
         vec_cnt_nx   = 8'h00;
         cov_nx       = 4'h0;
         timed_out_nx = 1'b0;
         pass_nx      = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Result and timeout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt    <= 8'h00;
         err_map   <= 8'h00;
         err_cnt   <= 8'h00;
         vec_cnt   <= 8'h00;
         cov       <= 4'h0;
         timed_out <= 1'b0;
         pass      <= 1'b0;
      end else begin
         to_cnt    <= to_cnt_nx;
         err_map   <= err_map_nx;
         err_cnt   <= err_cnt_nx;
         vec_cnt   <= vec_cnt_nx;
         cov       <= cov_nx;
         timed_out <= timed_out_nx;
         pass      <= pass_nx;
      end
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - table, directed and random checks of gate_response_checker
module tb_gate_response_checker;

   localparam int TO = 8;

   logic       clk;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic       a;
   logic       b;
   logic [7:0] gate_obs;
   logic       busy;
   logic       done;
   logic       pass;
   logic       timed_out;
   logic [7:0] err_map;
   logic [7:0] err_cnt;
   logic [7:0] vec_cnt;
   logic [3:0] cov;

   gate_response_checker #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .gate_obs(gate_obs), .busy(busy), .done(done), .pass(pass),
      .timed_out(timed_out), .err_map(err_map), .err_cnt(err_cnt), .vec_cnt(vec_cnt), .cov(cov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit       r, s, v;
      bit [1:0] ab;
      bit [7:0] obs;
      bit       e_busy, e_done, e_pass, e_to;
      bit [7:0] e_map, e_ec, e_vc;
      bit [3:0] e_cov;
   } row_t;

   row_t tbl[$];

   // Reference model state: session phase 0 idle, 1 running, 2 finished.
   int       m_phase;
   bit [7:0] m_map;
   int       m_errs, m_vecs, m_idle;
   bit       m_seen[4];
   bit       m_to, m_pass;

   function automatic bit [7:0] gold(bit x, bit y);
      return {~(x ^ y), ~(x | y), ~(x & y), x ^ y, ~y, ~x, x | y, x & y};
   endfunction

   function automatic bit [7:0] sat(int x);
      return (x > 255) ? 8'hFF : 8'(x);
   endfunction

   task automatic model_clear(int phase);
      m_phase = phase; m_map = 0; m_errs = 0; m_vecs = 0; m_idle = 0;
      m_to = 0; m_pass = 0;
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
   endtask

   task automatic model_step(bit r, bit s, bit v, bit [1:0] ab, bit [7:0] obs);
      bit [7:0] diff;
      if (r) model_clear(0);
      else if (s) model_clear(1);
      else if (m_phase == 1) begin
         if (v) begin
            diff = obs ^ gold(ab[1], ab[0]);
            m_map |= diff;
            if (diff != 0) m_errs++;
            m_vecs++;
            m_seen[ab] = 1;
            m_idle = 0;
            if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
               m_phase = 2;
               m_pass  = (m_map == 0);
            end
         end else begin
            m_idle++;
            if (m_idle >= TO) begin
               m_phase = 2;
               m_to    = 1;
            end
         end
      end
   endtask

   function automatic logic [32:0] model_vec();
      bit [3:0] c;
      for (int i = 0; i < 4; i++) c[i] = m_seen[i];
      return {m_phase == 1, m_phase == 1, m_phase == 2, m_pass, m_to, m_map, sat(m_errs), sat(m_vecs), c};
   endfunction

   function automatic logic [32:0] dut_vec();
      return {in_ready, busy, done, pass, timed_out, err_map, err_cnt, vec_cnt, cov};
   endfunction

   task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(bit r, bit s, bit v, bit [1:0] ab, bit [7:0] obs);
      rst = r; start = s; in_valid = v; a = ab[1]; b = ab[0]; gate_obs = obs;
      @(posedge clk);
      #1;
      model_step(r, s, v, ab, obs);
   endtask

   task automatic cyc(string name, bit r, bit s, bit v, bit [1:0] ab, bit [7:0] obs);
      drive(r, s, v, ab, obs);
      chk(name, dut_vec(), model_vec());
   endtask

   function automatic row_t mk(bit r, bit s, bit v, bit [1:0] ab, bit [7:0] obs,
                               bit eb, bit ed, bit ep, bit et,
                               bit [7:0] em, bit [7:0] ec, bit [7:0] ev, bit [3:0] cv);
      row_t t;
      t.r = r; t.s = s; t.v = v; t.ab = ab; t.obs = obs;
      t.e_busy = eb; t.e_done = ed; t.e_pass = ep; t.e_to = et;
      t.e_map = em; t.e_ec = ec; t.e_vc = ev; t.e_cov = cv;
      return t;
   endfunction

   initial begin
      bit       seen_done;
      int       n_wait;
      int       vprob;
      bit [1:0] rab;
      bit [7:0] robs;

      rst = 1; start = 0; in_valid = 0; a = 0; b = 0; gate_obs = 0;
      model_clear(0);

      // Golden run, restart in DONE with one bad gate, restart mid-run with a bad vector, reset mid-run.
      tbl.push_back(mk(1,0,0,2'd0,8'h00, 0,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,1,0,2'd0,8'h00, 1,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,1,2'd0,8'hEC, 1,0,0,0, 8'h00,8'd0,8'd1,4'h1));
      tbl.push_back(mk(0,0,1,2'd1,8'h36, 1,0,0,0, 8'h00,8'd0,8'd2,4'h3));
      tbl.push_back(mk(0,0,1,2'd2,8'h3A, 1,0,0,0, 8'h00,8'd0,8'd3,4'h7));
      tbl.push_back(mk(0,0,1,2'd3,8'h83, 0,1,1,0, 8'h00,8'd0,8'd4,4'hF));
      tbl.push_back(mk(0,0,1,2'd0,8'h00, 0,1,1,0, 8'h00,8'd0,8'd4,4'hF));
      tbl.push_back(mk(0,1,0,2'd0,8'h00, 1,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,1,2'd0,8'hEC, 1,0,0,0, 8'h00,8'd0,8'd1,4'h1));
      tbl.push_back(mk(0,0,1,2'd1,8'h36, 1,0,0,0, 8'h00,8'd0,8'd2,4'h3));
      tbl.push_back(mk(0,0,1,2'd2,8'h3A, 1,0,0,0, 8'h00,8'd0,8'd3,4'h7));
      tbl.push_back(mk(0,0,1,2'd3,8'h93, 0,1,0,0, 8'h10,8'd1,8'd4,4'hF));
      tbl.push_back(mk(0,1,0,2'd0,8'h00, 1,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,1,2'd0,8'hEC, 1,0,0,0, 8'h00,8'd0,8'd1,4'h1));
      tbl.push_back(mk(0,1,1,2'd1,8'hFF, 1,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,0,2'd0,8'h00, 1,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,1,2'd0,8'hEC, 1,0,0,0, 8'h00,8'd0,8'd1,4'h1));
      tbl.push_back(mk(0,0,1,2'd1,8'h36, 1,0,0,0, 8'h00,8'd0,8'd2,4'h3));
      tbl.push_back(mk(1,1,1,2'd2,8'h3A, 0,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,1,2'd3,8'h83, 0,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,1,0,2'd0,8'h00, 1,0,0,0, 8'h00,8'd0,8'd0,4'h0));
      tbl.push_back(mk(0,0,1,2'd0,8'hEC, 1,0,0,0, 8'h00,8'd0,8'd1,4'h1));
      tbl.push_back(mk(0,0,1,2'd1,8'h36, 1,0,0,0, 8'h00,8'd0,8'd2,4'h3));
      tbl.push_back(mk(0,0,1,2'd2,8'h3A, 1,0,0,0, 8'h00,8'd0,8'd3,4'h7));
      tbl.push_back(mk(0,0,1,2'd3,8'h83, 0,1,1,0, 8'h00,8'd0,8'd4,4'hF));

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].ab, tbl[i].obs);
         chk($sformatf("row%0d", i), dut_vec(),
             {tbl[i].e_busy, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pass, tbl[i].e_to,
              tbl[i].e_map, tbl[i].e_ec, tbl[i].e_vc, tbl[i].e_cov});
      end

      // Timeout: two golden vectors then silence; done must appear exactly TO cycles later.
      cyc("to_rst", 1, 0, 0, 2'd0, 8'h00);
      cyc("to_start", 0, 1, 0, 2'd0, 8'h00);
      cyc("to_v00", 0, 0, 1, 2'd0, gold(0, 0));
      cyc("to_v01", 0, 0, 1, 2'd1, gold(0, 1));
      seen_done = 0;
      n_wait = 0;
      while (!seen_done && n_wait < 20) begin
         cyc("to_wait", 0, 0, 0, 2'd0, 8'h00);
         n_wait++;
         seen_done = (done === 1'b1);
      end
      chk("to_latency", 33'(n_wait), 33'(TO));
      chk("to_flags", {31'd0, timed_out, pass}, {31'd0, 1'b1, 1'b0});
      chk("to_cov", 33'(cov), 33'(4'b0011));
      cyc("to_hold", 0, 0, 1, 2'd3, gold(1, 1));

      // Duplicates: 00 three times then the rest, all golden.
      cyc("dup_start", 0, 1, 0, 2'd0, 8'h00);
      for (int i = 0; i < 3; i++) cyc("dup_00", 0, 0, 1, 2'd0, gold(0, 0));
      cyc("dup_01", 0, 0, 1, 2'd1, gold(0, 1));
      cyc("dup_10", 0, 0, 1, 2'd2, gold(1, 0));
      cyc("dup_11", 0, 0, 1, 2'd3, gold(1, 1));
      chk("dup_result", {24'd0, vec_cnt, pass}, {24'd0, 8'd6, 1'b1});

      // Saturation: 300 erroneous 00 vectors back to back never complete coverage.
      cyc("sat_start", 0, 1, 0, 2'd0, 8'h00);
      for (int i = 0; i < 300; i++) drive(0, 0, 1, 2'd0, gold(0, 0) ^ 8'h01);
      chk("sat_model", dut_vec(), model_vec());
      chk("sat_counts", {17'd0, err_cnt, vec_cnt}, {17'd0, 8'hFF, 8'hFF});

      // Randomized traffic against the reference model.
      cyc("rnd_rst", 1, 0, 0, 2'd0, 8'h00);
      vprob = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 50 == 0) begin
            case ($urandom_range(0, 3))
               0: vprob = 0;
               1: vprob = 20;
               2: vprob = 60;
               default: vprob = 100;
            endcase
         end
         rab  = 2'($urandom_range(0, 3));
         robs = gold(rab[1], rab[0]);
         if ($urandom_range(0, 9) == 0) robs ^= 8'(1 << $urandom_range(0, 7));
         cyc("random", $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 99) < vprob, rab, robs);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
